exec_controller: RTL and testbench
==================================

Name: exec_controller

Overview:
- Upstream run-control stage for the ASIP core. Conditions the board controls: pwr and dbg switches, stp button.
- Produces a glitch-free, synchronous clock-enable (cpu_en) that the top level feeds to the processor's enable path. This replaces combinational clock gating.
- Implements free-run mode and debug single-step mode. Exposes status and an executed-cycle counter for board LEDs and the bench.

Parameters:
- N, 32, width of cycle_count.
- DEB_CYCLES, 16, consecutive stable synchronized samples required to accept a new stp level.
- STEP_CYCLES, 1, cycles of cpu_en per accepted step press (>=1).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (>=2).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous reset, active-low.
- pwr, input, 1, power switch, asynchronous. A falling edge starts the core.
- dbg, input, 1, debug-mode switch, asynchronous.
- stp, input, 1, step button, asynchronous, active-high, bouncy.
- cpu_en, output, 1, processor clock-enable.
- powered, output, 1, high once a power-up has been accepted.
- mode, output, 2, 00 OFF, 01 RUN, 10 DBG_IDLE, 11 DBG_STEP.
- step_pulse, output, 1, one-cycle strobe when a step press is accepted.
- cycle_count, output, N, number of cycles with cpu_en=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - State OFF. All outputs 0.
  - Synchronizers cleared to 0. Debounce counter and step counter cleared.
  - The debounced stp level is cleared to 0.
- Input conditioning:
  - pwr, dbg and stp each pass through SYNC_STAGES flip-flops, giving pwr_s, dbg_s and stp_s.
  - stp_s is debounced. The internal level stp_d changes only after stp_s differs from stp_d for DEB_CYCLES consecutive cycles. Any equal sample resets the counter.
  - An accepted press is a 0->1 transition of stp_d.
- Power-up:
  - In OFF, a 1->0 transition of pwr_s moves the state to RUN if dbg_s=0, or to DBG_IDLE if dbg_s=1.
  - pwr_s held at 0 out of reset is not an edge. The prior sample must have been 1.
  - powered rises in the cycle the state leaves OFF.
  - powered is sticky: later pwr changes are ignored until rst.
- FSM, registered, with cpu_en a registered function of the next state:
  - OFF: cpu_en=0.
  - RUN: cpu_en=1 every cycle. When dbg_s=1, go to DBG_IDLE. cpu_en drops in the same cycle mode reads 10.
  - DBG_IDLE: cpu_en=0.
    - If dbg_s=0, go to RUN.
    - Else, on an accepted press, go to DBG_STEP. step_pulse=1 for that one cycle. Load the step counter with STEP_CYCLES.
  - DBG_STEP: cpu_en=1 for exactly STEP_CYCLES cycles, starting the cycle after step_pulse.
    - The counter decrements each cycle.
    - When the counter reaches 0, go to DBG_IDLE if dbg_s=1, else RUN.
    - A dbg change mid-burst never truncates or extends the burst.
- Presses:
  - Presses accepted during DBG_STEP or RUN are discarded, not queued.
  - A held button produces only one press.
- cycle_count:
  - Increments by 1 in every cycle cpu_en=1.
  - Wraps from all-ones to 0. No saturation.
  - Holds while cpu_en=0.
- Latency:
  - pwr falling at the pin to cpu_en=1 is at most SYNC_STAGES+2 cycles.
  - Stable stp press to step_pulse is SYNC_STAGES+DEB_CYCLES+1 cycles.
- Reset mid-operation:
  - cpu_en drops asynchronously. The state returns to OFF.
  - A new pwr falling edge is required to restart.
- Simultaneous events:
  - A press in the same cycle dbg_s falls, in DBG_IDLE: RUN wins and the press is discarded.
  - A pwr edge and dbg_s=1 arriving together: enter DBG_IDLE.

Decomposition:
- Package exec_ctrl_pkg:
  - typedef enum logic [1:0] state_t {OFF=2'b00, RUN=2'b01, DBG_IDLE=2'b10, DBG_STEP=2'b11}. mode is driven directly from state_t.
  - Default constants for DEB_CYCLES and STEP_CYCLES.
- Sub-module input_debouncer:
  - Parameters SYNC_STAGES and DEB_CYCLES.
  - Ports: clk, rst, async_in, level_out, rise_pulse.
  - Instantiated once for stp.
  - pwr and dbg use plain synchronizers inside exec_controller.

Test Plan:
- Reset and power-up: rst=0 for 3 cycles with pwr=1 and dbg=0. Release rst, then drive pwr 1->0.
  - Required: all outputs 0 during reset.
  - Required: powered=1, mode=01 and cpu_en=1 within 4 cycles. cycle_count reaches 10 after 10 enabled cycles.
- Debug step: power up with dbg=1 (mode=10, cpu_en=0). Hold stp=1 for 30 cycles with DEB_CYCLES=16.
  - Required: exactly one step_pulse.
  - Required: cpu_en=1 for 1 cycle; cycle_count increments by 1; mode returns to 10.
- Bounce rejection: toggle stp every 5 cycles for 60 cycles in DBG_IDLE.
  - Required: no step_pulse, cpu_en stays 0, cycle_count unchanged.
- Mode switching: set STEP_CYCLES=4, start a step, then drop dbg during the 2nd enabled cycle.
  - Required: the full 4-cycle burst completes, then mode=01 with continuous cpu_en.
  - Then raise dbg. Required: cpu_en=0 and mode=10 within SYNC_STAGES+1 cycles.
- Reset mid-run: assert rst in RUN while cycle_count=25.
  - Required: cpu_en, powered and cycle_count are 0 immediately (asynchronous).
  - After release, cpu_en stays 0 until a new pwr 1->0 edge.
- Wrap: N=4, run 17 enabled cycles.
  - Required: cycle_count sequence passes 15 -> 0, ending at 1.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// rtl/exec_ctrl_pkg.sv - shared types and defaults for the run-control stage
package exec_ctrl_pkg;

    // Run-control states; the encoding is also the value presented on mode.
    typedef enum logic [1:0] {
        OFF      = 2'b00,
        RUN      = 2'b01,
        DBG_IDLE = 2'b10,
        DBG_STEP = 2'b11
    } state_t;

    localparam int DEF_N           = 32;
    localparam int DEF_DEB_CYCLES  = 16;
    localparam int DEF_STEP_CYCLES = 1;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed to hold the value 0..value inclusive (at least one bit).
    function automatic int cnt_width(input int value);
        if (value < 2) begin
            return 1;
        end
        return $clog2(value + 1);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronizer plus counter debouncer with rising-edge strobe
module input_debouncer
    import exec_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int              CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;

    assign sync_s     = sync_q[SYNC_STAGES-1];
    assign level_out  = level_q;
    assign rise_pulse = rise_q;

    // Shift the raw pin through the synchronizer chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
            cnt_d   = '0;
            level_d = sync_s;
            rise_d  = sync_s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

endmodule

// File: rtl/exec_controller.sv
// rtl/exec_controller.sv - run/debug-step controller producing a registered cpu clock-enable
module exec_controller
    import exec_ctrl_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwr,
    input  logic         dbg,
    input  logic         stp,
    output logic         cpu_en,
    output logic         powered,
    output logic [1:0]   mode,
    output logic         step_pulse,
    output logic [N-1:0] cycle_count
);

    localparam int             SCW       = cnt_width(STEP_CYCLES);
    localparam logic [SCW-1:0] STEP_LOAD = SCW'(STEP_CYCLES);

    logic [SYNC_STAGES-1:0] pwr_sync_q;
    logic [SYNC_STAGES-1:0] dbg_sync_q;
    logic                   pwr_s;
    logic                   dbg_s;
    logic                   pwr_prev_q;
    logic                   pwr_fall;

    logic                   stp_level;
    logic                   stp_rise;
    logic                   stp_press;

    state_t                 state_q, state_d;
    logic [SCW-1:0]         step_cnt_q, step_cnt_d;
    logic                   cpu_en_q, cpu_en_d;
    logic                   powered_q, powered_d;
    logic                   step_pulse_q, step_pulse_d;
    logic [N-1:0]           cycle_cnt_q, cycle_cnt_d;

    assign pwr_s    = pwr_sync_q[SYNC_STAGES-1];
    assign dbg_s    = dbg_sync_q[SYNC_STAGES-1];
    // A falling edge needs a genuine prior high sample; reset clears pwr_prev_q.
    assign pwr_fall = pwr_prev_q & ~pwr_s;
    // rise and level update on the same edge, so the AND only confirms the press.
    assign stp_press = stp_rise & stp_level;

    input_debouncer #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) u_stp_debouncer (
        .clk        (clk),
        .rst        (rst),
        .async_in   (stp),
        .level_out  (stp_level),
        .rise_pulse (stp_rise)
    );

    // Synchronize the switch inputs and remember the previous pwr sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwr_sync_q <= '0;
            dbg_sync_q <= '0;
            pwr_prev_q <= 1'b0;
        end else begin
            pwr_sync_q <= {pwr_sync_q[SYNC_STAGES-2:0], pwr};
            dbg_sync_q <= {dbg_sync_q[SYNC_STAGES-2:0], dbg};
            pwr_prev_q <= pwr_s;
        end
    end

    // Next-state logic; cpu_en is derived from where the FSM is going next.
    always_comb begin
        state_d      = state_q;
        step_cnt_d   = step_cnt_q;
        step_pulse_d = 1'b0;
        powered_d    = powered_q;
        case (state_q)
            OFF: begin
                if (pwr_fall) begin
                    state_d = dbg_s ? DBG_IDLE : RUN;
                end
            end
            RUN: begin
                if (dbg_s) begin
                    state_d = DBG_IDLE;
                end
            end
            DBG_IDLE: begin
                // Leaving debug takes priority over a coincident press.
                if (!dbg_s) begin
                    state_d = RUN;
                end else if (stp_press) begin
                    state_d      = DBG_STEP;
                    step_cnt_d   = STEP_LOAD;
                    step_pulse_d = 1'b1;
                end
            end
            DBG_STEP: begin
                // The burst length is fixed at entry; dbg is only consulted at the end.
                if (step_cnt_q != '0) begin
                    step_cnt_d = step_cnt_q - 1'b1;
                end else begin
                    state_d = dbg_s ? DBG_IDLE : RUN;
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
        if (state_d != OFF) begin
            powered_d = 1'b1;
        end
        cpu_en_d    = (state_d == RUN) || ((state_q == DBG_STEP) && (step_cnt_q != '0));
        cycle_cnt_d = cycle_cnt_q + N'(cpu_en_q);
    end

    // State and output registers; reset forces cpu_en low asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= OFF;
            step_cnt_q   <= '0;
            cpu_en_q     <= 1'b0;
            powered_q    <= 1'b0;
            step_pulse_q <= 1'b0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            cpu_en_q     <= cpu_en_d;
            powered_q    <= powered_d;
            step_pulse_q <= step_pulse_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign powered     = powered_q;
    assign mode        = state_q;
    assign step_pulse  = step_pulse_q;
    assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_exec_controller.sv
// tb/tb_exec_controller.sv - directed plus randomized bench with a behavioural reference model
module tb_exec_controller;

    localparam int S   = 2;
    localparam int DEB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pwr = 1'b1;
    logic dbg = 1'b0;
    logic stp = 1'b0;

    logic        a_en, a_pow, a_pulse;
    logic [1:0]  a_mode;
    logic [31:0] a_cnt;
    logic        b_en, b_pow, b_pulse;
    logic [1:0]  b_mode;
    logic [3:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    exec_controller #(.N(32), .DEB_CYCLES(DEB), .STEP_CYCLES(1), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp),
        .cpu_en(a_en), .powered(a_pow), .mode(a_mode), .step_pulse(a_pulse), .cycle_count(a_cnt)
    );

    exec_controller #(.N(4), .DEB_CYCLES(DEB), .STEP_CYCLES(4), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .rst(rst), .pwr(pwr), .dbg(dbg), .stp(stp),
        .cpu_en(b_en), .powered(b_pow), .mode(b_mode), .step_pulse(b_pulse), .cycle_count(b_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: pins delayed S edges, window debounce, mode as integer.
    int     step_of [2] = '{1, 4};
    longint mask_of [2] = '{64'hFFFF_FFFF, 64'hF};
    bit     q_pwr[$], q_dbg[$], q_stp[$], stp_hist[$];
    bit     m_pwr_s, m_pwr_prev, m_dbg_s, m_stp_s, m_lvl, m_rise;
    int     m_mode[2], m_burst[2];
    bit     m_en[2], m_pulse[2], m_pow[2];
    longint m_cnt[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_pwr.delete(); q_dbg.delete(); q_stp.delete(); stp_hist.delete();
        m_pwr_s = 0; m_pwr_prev = 0; m_dbg_s = 0; m_stp_s = 0; m_lvl = 0; m_rise = 0;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_burst[i] = 0; m_en[i] = 0; m_pulse[i] = 0; m_pow[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit all_diff;
        for (int i = 0; i < 2; i++) begin
            int om = m_mode[i];
            int nm = om;
            int ob = m_burst[i];
            bit np = 0;
            m_cnt[i] = (m_cnt[i] + longint'(m_en[i])) & mask_of[i];
            case (om)
                0: if (m_pwr_prev && !m_pwr_s) nm = m_dbg_s ? 2 : 1;
                1: if (m_dbg_s) nm = 2;
                2: begin
                    if (!m_dbg_s) nm = 1;
                    else if (m_rise) begin nm = 3; m_burst[i] = step_of[i]; np = 1; end
                end
                default: begin
                    if (ob > 0) m_burst[i] = ob - 1;
                    else nm = m_dbg_s ? 2 : 1;
                end
            endcase
            m_en[i]    = (nm == 1) || (om == 3 && ob > 0);
            m_pulse[i] = np;
            if (nm != 0) m_pow[i] = 1;
            m_mode[i] = nm;
        end
        // Level flips when the last DEB synchronized samples all disagree with it.
        stp_hist.push_back(m_stp_s);
        if (stp_hist.size() > DEB) void'(stp_hist.pop_front());
        all_diff = (stp_hist.size() == DEB);
        foreach (stp_hist[k]) if (stp_hist[k] == m_lvl) all_diff = 0;
        m_rise = 0;
        if (all_diff) begin
            m_lvl  = !m_lvl;
            m_rise = m_lvl;
            stp_hist.delete();
        end
        m_pwr_prev = m_pwr_s;
        q_pwr.push_back(pwr); q_dbg.push_back(dbg); q_stp.push_back(stp);
        if (q_pwr.size() > S) begin
            void'(q_pwr.pop_front()); void'(q_dbg.pop_front()); void'(q_stp.pop_front());
        end
        m_pwr_s = (q_pwr.size() == S) ? q_pwr[0] : 1'b0;
        m_dbg_s = (q_dbg.size() == S) ? q_dbg[0] : 1'b0;
        m_stp_s = (q_stp.size() == S) ? q_stp[0] : 1'b0;
    endtask

    task automatic compare_all();
        chk("a_cpu_en", a_en, m_en[0]);
        chk("a_powered", a_pow, m_pow[0]);
        chk("a_mode", a_mode, m_mode[0]);
        chk("a_step_pulse", a_pulse, m_pulse[0]);
        chk("a_cycle_count", a_cnt, m_cnt[0][31:0]);
        chk("b_cpu_en", b_en, m_en[1]);
        chk("b_powered", b_pow, m_pow[1]);
        chk("b_mode", b_mode, m_mode[1]);
        chk("b_step_pulse", b_pulse, m_pulse[1]);
        chk("b_cycle_count", b_cnt, m_cnt[1][31:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        int lat, pulses, a_ens, b_ens, bursts, gaps, hold;
        logic [31:0] base_a;
        logic [3:0]  base_b;

        model_reset();
        rst = 0; pwr = 1; dbg = 0; stp = 0;
        repeat (3) begin
            tick();
            chk("rst_cpu_en", a_en, 0);
            chk("rst_powered", a_pow, 0);
            chk("rst_mode", a_mode, 0);
            chk("rst_count", a_cnt, 0);
        end
        #2 rst = 1;
        repeat (4) tick();

        // Power-up into RUN.
        pwr = 0;
        lat = 0;
        while (a_en !== 1'b1 && lat < 6) begin tick(); lat++; end
        chk("pwrup_latency_le4", lat <= S + 2, 1);
        chk("pwrup_powered", a_pow, 1);
        chk("pwrup_mode_run", a_mode, 1);

        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 10) chk("count_10", a_cnt, 10);
            if (k == 15) chk("wrap_15", b_cnt, 15);
            if (k == 16) chk("wrap_0", b_cnt, 0);
            if (k == 17) chk("wrap_end_1", b_cnt, 1);
            if (k == 25) chk("count_25", a_cnt, 25);
        end

        // Asynchronous reset mid-run.
        #2 rst = 0;
        #1;
        chk("async_rst_cpu_en", a_en, 0);
        chk("async_rst_powered", a_pow, 0);
        chk("async_rst_count", a_cnt, 0);
        chk("async_rst_b_cpu_en", b_en, 0);
        model_reset();
        compare_all();
        tick(); tick();
        #2 rst = 1;
        repeat (20) begin
            tick();
            chk("no_restart_cpu_en", a_en, 0);
        end

        // Power edge together with dbg: straight into DBG_IDLE.
        pwr = 1;
        repeat (5) tick();
        dbg = 1; pwr = 0;
        repeat (6) tick();
        chk("dbg_pwrup_mode", a_mode, 2);
        chk("dbg_pwrup_powered", a_pow, 1);
        chk("dbg_pwrup_cpu_en", a_en, 0);

        // Held step button: one press, one burst.
        base_a = a_cnt; base_b = b_cnt;
        pulses = 0; a_ens = 0; b_ens = 0; lat = 0;
        stp = 1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (a_pulse === 1'b1) begin pulses++; if (lat == 0) lat = k; end
            if (a_en === 1'b1) a_ens++;
            if (b_en === 1'b1) b_ens++;
        end
        chk("step_pulse_count", pulses, 1);
        chk("step_pulse_latency", lat, S + DEB + 1);
        chk("a_burst_len", a_ens, 1);
        chk("a_step_count", a_cnt, base_a + 1);
        chk("b_burst_len", b_ens, 4);
        chk("b_step_count", b_cnt, 4'(base_b + 4'd4));
        chk("a_back_idle", a_mode, 2);
        stp = 0;
        repeat (25) tick();

        // Bouncy button: runs of 5 never satisfy the debouncer.
        base_a = a_cnt; base_b = b_cnt;
        pulses = 0; a_ens = 0;
        for (int k = 0; k < 60; k++) begin
            if (k % 5 == 0) stp = ~stp;
            tick();
            if (a_pulse === 1'b1 || b_pulse === 1'b1) pulses++;
            if (a_en === 1'b1 || b_en === 1'b1) a_ens++;
        end
        chk("bounce_pulses", pulses, 0);
        chk("bounce_cpu_en", a_ens, 0);
        chk("bounce_a_count", a_cnt, base_a);
        chk("bounce_b_count", b_cnt, base_b);
        stp = 0;
        repeat (25) tick();

        // Drop dbg in the 2nd enabled cycle of a 4-cycle burst.
        stp = 1;
        lat = 0;
        while (b_pulse !== 1'b1 && lat < 40) begin tick(); lat++; end
        chk("b_pulse_seen", b_pulse, 1);
        bursts = 0; gaps = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (b_mode === 2'b11 && b_en === 1'b1) bursts++;
            if (b_en !== 1'b1) gaps++;
            if (k == 2) dbg = 0;
        end
        chk("burst_not_truncated", bursts, 4);
        chk("run_continuous", gaps, 0);
        chk("burst_then_run", b_mode, 1);
        stp = 0;

        // Raise dbg again: stop within SYNC_STAGES+1 cycles.
        dbg = 1;
        lat = 0;
        while ((b_mode !== 2'b10 || b_en !== 1'b0) && lat < 6) begin tick(); lat++; end
        chk("dbg_stop_latency", lat <= S + 1, 1);
        chk("dbg_stop_mode", b_mode, 2);
        chk("dbg_stop_cpu_en", b_en, 0);

        // Randomized traffic against the model, including a reset.
        hold = 0;
        for (int k = 0; k < 1500; k++) begin
            if (hold == 0) begin
                stp  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 40);
            end
            hold--;
            if ($urandom_range(0, 59) == 0) dbg = ~dbg;
            if ($urandom_range(0, 29) == 0) pwr = ~pwr;
            if (k == 700) rst = 0;
            if (k == 703) rst = 1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
